barcode_accumulator: RTL and testbench
======================================

Name: barcode_accumulator

Overview:
Parametrised successor to the keyboard/scanner barcode front end. It takes the ASCII key stream from the PS/2 decoder, stores digits in a bounded buffer with backspace and clear support, and on Enter converts the buffer to a binary value over several cycles. The value is presented to the SHA block on a valid/ready handshake. It sits between key2ascii/Kbd_ctrl and the hash input register, and supports radix 10, 16 and 36.

Parameters:
RADIX_MODE, 0, digit alphabet: 0 = decimal, 1 = hex, 2 = base36 (0-9, A-Z)
VALUE_W, 32, width of the converted value
MAX_DIGITS, 12, digit buffer depth (>=1)
CNT_W, $clog2(MAX_DIGITS+1), width of the digit counter

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
key_ready  in  1  level data_ready from the keyboard controller, already synchronised to clk
key_ascii  in  8  ASCII code; valid in the cycle key_ready is first seen high
code_data  out  VALUE_W  converted barcode
code_valid  out  1  code_data/code_digits/code_overflow are valid
code_ready  in  1  consumer accepts when code_valid && code_ready
code_digits  out  CNT_W  number of digits in the presented code
code_overflow  out  1  digits were truncated or the value wrapped
digit_count  out  CNT_W  live buffer occupancy
busy  out  1  high in CONVERT or PRESENT
key_dropped  out  1  one-cycle pulse when a key is ignored because busy

Behaviour:
- Async reset: state = COLLECT; buffer count = 0. All outputs are 0, including code_data and the stored previous key_ready.
- Key event: rising edge of key_ready (key_ready=1 and the registered previous value = 0). Exactly one event per edge. Holding key_ready high produces no repeats.
- Digit decode:
  - '0'-'9' map to 0-9.
  - In hex, 'A'-'F' and 'a'-'f' map to 10-15.
  - In base36, 'A'-'Z' and 'a'-'z' map to 10-35.
  - Any other character is a non-digit.
- COLLECT, applied to the event:
  - Digit with count < MAX_DIGITS: write the digit to buf[count], then count+1.
  - Digit with count == MAX_DIGITS: discard it and set the sticky trunc flag.
  - Backspace 0x08: if count > 0, count-1; if count = 0, no effect. Does not clear trunc.
  - Clear: 'R'/'r' in modes 0/1, '-' in mode 2 (R is a digit there). Sets count = 0 and trunc = 0.
  - Enter 0x0D with count > 0: acc = 0, idx = 0, wrap = 0, go to CONVERT.
  - Enter with count = 0: ignored.
  - All other characters: ignored.
- CONVERT: one digit per cycle.
  - acc = acc*R + buf[idx], truncated to VALUE_W bits.
  - wrap |= any carry out beyond VALUE_W bits.
  - idx+1. After the idx = count-1 step, go to PRESENT.
  - R is the constant 10, 16 or 36.
- PRESENT: code_valid = 1 with code_data = acc, code_digits = count, code_overflow = trunc|wrap.
  - Outputs are held stable while code_ready = 0.
  - On a handshake: code_valid drops the next cycle, count = 0, trunc = 0, state returns to COLLECT.
- Latency: Enter event seen in cycle k; CONVERT covers cycles k+1..k+N for N digits; code_valid is first high in cycle k+N+1. A same-cycle code_ready gives a 1-cycle PRESENT.
- Keys in CONVERT/PRESENT: not applied; key_dropped pulses for the cycle of the event.
- Handshake cycle coinciding with a key event: the key is dropped, because the state is still PRESENT.
- Reset mid-CONVERT or mid-PRESENT: immediate return to the reset state; the pending code is lost.
- Buffer contents beyond count are don't-care; reading them is never allowed to affect acc.
- The multiply uses a shift-add for R = 10, 16 or 36. No divider is permitted.

Decomposition:
- Package barcode_pkg:
  - ASCII constants: enter 0x0D, backspace 0x08, clear characters.
  - State enum {COLLECT, CONVERT, PRESENT}.
  - Radix-mode constants.
  - Function radix_of(mode).
- Sub-module ascii_digit_decode: combinational (ascii, mode) -> {is_digit, digit[5:0], is_bs, is_clear, is_enter}.
- The buffer, FSM and accumulator stay in the top module.

Test Plan:
- Mode 0, keys "1","2","3","4",Enter, code_ready=1 -> code_data=0x000004D2, code_digits=4, overflow=0, code_valid high exactly 5 cycles after the Enter edge.
- Mode 0, "1","2","9",BS,"3",Enter -> 123. Then "R","7",Enter -> 7. BS with an empty buffer then Enter -> no code_valid.
- Mode 1, "d","E","a","D",Enter -> 0x0000DEAD. Mode 2, "Z","Z",Enter -> 1295. Mode 2, '-' clears while 'R' decodes as 27.
- Mode 0, MAX_DIGITS=12, 13 digits "1234567890123",Enter -> code_digits=12, code_overflow=1. Same run with "4294967296" -> code_data=0, code_overflow=1.
- Hold code_ready=0 for 20 cycles in PRESENT with 3 key events -> outputs stable, 3 key_dropped pulses, digit_count unchanged. Then ready=1 -> single transfer and digit_count=0.
- Assert reset during CONVERT of a 6-digit code -> code_valid=0, digit_count=0, busy=0. Holding key_ready high for 100 cycles -> exactly one digit stored.

Source files
------------

// File: rtl/barcode_pkg.sv
// Shared constants, state type and radix helper for the barcode accumulator.
package barcode_pkg;

    localparam logic [7:0] ASCII_ENTER   = 8'h0D;
    localparam logic [7:0] ASCII_BS      = 8'h08;
    localparam logic [7:0] ASCII_CLR_UC  = 8'h52;  // 'R'
    localparam logic [7:0] ASCII_CLR_LC  = 8'h72;  // 'r'
    localparam logic [7:0] ASCII_CLR_B36 = 8'h2D;  // '-'; R is a digit in base36

    localparam logic [1:0] MODE_DEC = 2'd0;
    localparam logic [1:0] MODE_HEX = 2'd1;
    localparam logic [1:0] MODE_B36 = 2'd2;

    typedef enum logic [1:0] {COLLECT, CONVERT, PRESENT} state_t;

    function automatic int unsigned radix_of(input logic [1:0] mode);
        case (mode)
            MODE_HEX: return 16;
            MODE_B36: return 36;
            default:  return 10;
        endcase
    endfunction

endpackage

// File: rtl/barcode_accumulator_decode.sv
// Combinational ASCII classifier: digit value per radix mode plus control keys.
module ascii_digit_decode
    import barcode_pkg::*;
(
    input  logic [7:0] ascii,
    input  logic [1:0] mode,
    output logic       is_digit,
    output logic [5:0] digit,
    output logic       is_bs,
    output logic       is_clear,
    output logic       is_enter
);

    always_comb begin
        is_digit = 1'b0;
        digit    = '0;
        is_bs    = (ascii == ASCII_BS);
        is_enter = (ascii == ASCII_ENTER);
        is_clear = (mode == MODE_B36) ? (ascii == ASCII_CLR_B36)
                                      : (ascii == ASCII_CLR_UC || ascii == ASCII_CLR_LC);
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            is_digit = 1'b1;
            digit    = 6'(ascii - 8'h30);
        end else if (ascii >= 8'h41 && ascii <= 8'h5A) begin
            if (mode == MODE_B36 || (mode == MODE_HEX && ascii <= 8'h46)) begin
                is_digit = 1'b1;
                digit    = 6'(ascii - 8'h37);
            end
        end else if (ascii >= 8'h61 && ascii <= 8'h7A) begin
            if (mode == MODE_B36 || (mode == MODE_HEX && ascii <= 8'h66)) begin
                is_digit = 1'b1;
                digit    = 6'(ascii - 8'h57);
            end
        end
    end

endmodule

// File: rtl/barcode_accumulator.sv
// Key-stream digit buffer with backspace/clear, serial radix conversion on Enter,
// and valid/ready presentation of the converted value.
module barcode_accumulator
    import barcode_pkg::*;
#(
    parameter int unsigned RADIX_MODE = 0,
    parameter int unsigned VALUE_W    = 32,
    parameter int unsigned MAX_DIGITS = 12,
    parameter int unsigned CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_ready,
    input  logic [7:0]         key_ascii,
    output logic [VALUE_W-1:0] code_data,
    output logic               code_valid,
    input  logic               code_ready,
    output logic [CNT_W-1:0]   code_digits,
    output logic               code_overflow,
    output logic [CNT_W-1:0]   digit_count,
    output logic               busy,
    output logic               key_dropped
);

    localparam logic [1:0]       MODE  = 2'(RADIX_MODE);
    localparam int unsigned      RADIX = radix_of(MODE);
    localparam int unsigned      WIDE  = VALUE_W + 6;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(MAX_DIGITS);

    state_t             state;
    logic               key_prev;
    logic               key_event;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   idx;
    logic               trunc;
    logic               wrap;
    logic [VALUE_W-1:0] acc;
    logic [5:0]         digit_buf [MAX_DIGITS];
    logic [5:0]         cur_digit;
    logic [WIDE-1:0]    ext;
    logic [WIDE-1:0]    prod;

    logic       is_digit, is_bs, is_clear, is_enter;
    logic [5:0] key_digit;

    ascii_digit_decode u_decode (
        .ascii    (key_ascii),
        .mode     (MODE),
        .is_digit (is_digit),
        .digit    (key_digit),
        .is_bs    (is_bs),
        .is_clear (is_clear),
        .is_enter (is_enter)
    );

    assign key_event = key_ready & ~key_prev;
    assign cur_digit = digit_buf[idx];

    // Shift-add multiply by the constant radix; the extra 6 bits catch the carry-out.
    always_comb begin
        ext = WIDE'(acc);
        case (RADIX)
            16:      prod = ext << 4;
            36:      prod = (ext << 5) + (ext << 2);
            default: prod = (ext << 3) + (ext << 1);
        endcase
        prod = prod + WIDE'(cur_digit);
    end

    always_ff @(posedge clk) begin
        if (state == COLLECT && key_event && is_digit && count < FULL)
            digit_buf[count] <= key_digit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= COLLECT;
            key_prev <= 1'b0;
            count    <= '0;
            idx      <= '0;
            trunc    <= 1'b0;
            wrap     <= 1'b0;
            acc      <= '0;
        end else begin
            key_prev <= key_ready;
            case (state)
                COLLECT: begin
                    if (key_event) begin
                        if (is_digit) begin
                            if (count < FULL) count <= count + CNT_W'(1);
                            else              trunc <= 1'b1;
                        end else if (is_bs) begin
                            if (count != '0) count <= count - CNT_W'(1);
                        end else if (is_clear) begin
                            count <= '0;
                            trunc <= 1'b0;
                        end else if (is_enter && count != '0) begin
                            acc   <= '0;
                            idx   <= '0;
                            wrap  <= 1'b0;
                            state <= CONVERT;
                        end
                    end
                end
                CONVERT: begin
                    acc  <= prod[VALUE_W-1:0];
                    wrap <= wrap | (|prod[WIDE-1:VALUE_W]);
                    idx  <= idx + CNT_W'(1);
                    if (idx == count - CNT_W'(1)) state <= PRESENT;
                end
                PRESENT: begin
                    if (code_ready) begin
                        state <= COLLECT;
                        count <= '0;
                        trunc <= 1'b0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign code_valid    = (state == PRESENT);
    assign busy          = (state != COLLECT);
    assign key_dropped   = key_event & busy;
    assign digit_count   = count;
    assign code_data     = code_valid ? acc : '0;
    assign code_digits   = code_valid ? count : '0;
    assign code_overflow = code_valid & (trunc | wrap);

endmodule

// File: tb/tb_barcode_accumulator.sv
// Directed bench: one accumulator per radix mode, sharing clock, reset and key byte.
module tb_barcode_accumulator;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] kr;
    logic [7:0] key_ascii;
    logic       code_ready;

    logic [31:0] cdata  [3];
    logic        cvalid [3];
    logic [3:0]  cdig   [3];
    logic        covf   [3];
    logic [3:0]  dcnt   [3];
    logic        bsy    [3];
    logic        kdrop  [3];

    int checks   = 0;
    int failures = 0;

    always #10 clk = ~clk;

    barcode_accumulator #(.RADIX_MODE(0), .VALUE_W(32), .MAX_DIGITS(12)) u_dec (
        .clk(clk), .reset(reset), .key_ready(kr[0]), .key_ascii(key_ascii),
        .code_data(cdata[0]), .code_valid(cvalid[0]), .code_ready(code_ready),
        .code_digits(cdig[0]), .code_overflow(covf[0]), .digit_count(dcnt[0]),
        .busy(bsy[0]), .key_dropped(kdrop[0])
    );

    barcode_accumulator #(.RADIX_MODE(1), .VALUE_W(32), .MAX_DIGITS(12)) u_hex (
        .clk(clk), .reset(reset), .key_ready(kr[1]), .key_ascii(key_ascii),
        .code_data(cdata[1]), .code_valid(cvalid[1]), .code_ready(code_ready),
        .code_digits(cdig[1]), .code_overflow(covf[1]), .digit_count(dcnt[1]),
        .busy(bsy[1]), .key_dropped(kdrop[1])
    );

    barcode_accumulator #(.RADIX_MODE(2), .VALUE_W(32), .MAX_DIGITS(12)) u_b36 (
        .clk(clk), .reset(reset), .key_ready(kr[2]), .key_ascii(key_ascii),
        .code_data(cdata[2]), .code_valid(cvalid[2]), .code_ready(code_ready),
        .code_digits(cdig[2]), .code_overflow(covf[2]), .digit_count(dcnt[2]),
        .busy(bsy[2]), .key_dropped(kdrop[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic press(input int d, input logic [7:0] c);
        @(posedge clk); #1;
        key_ascii = c;
        kr[d]     = 1'b1;
        @(posedge clk); #1;
        kr[d]     = 1'b0;
    endtask

    task automatic type_str(input int d, input string s);
        for (int i = 0; i < s.len(); i++) press(d, s[i]);
    endtask

    task automatic get_code(input int d, input string tag, input logic [31:0] exp_data,
                            input logic [3:0] exp_dig, input logic exp_ovf);
        bit seen = 1'b0;
        press(d, 8'h0D);
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (cvalid[d]) seen = 1'b1;
        end
        check({tag, "_valid"}, 64'(seen), 64'd1);
        check({tag, "_data"},  64'(cdata[d]), 64'(exp_data));
        check({tag, "_digits"}, 64'(cdig[d]), 64'(exp_dig));
        check({tag, "_ovf"},   64'(covf[d]), 64'(exp_ovf));
        @(posedge clk); #1;
        check({tag, "_cnt0"},  64'(dcnt[d]), 64'd0);
    endtask

    initial begin
        bit seen;
        int drops;
        bit stable;

        reset      = 1'b1;
        kr         = '0;
        key_ascii  = 8'h00;
        code_ready = 1'b1;
        #5;
        check("rst_valid", 64'(cvalid[0]), 64'd0);
        check("rst_data",  64'(cdata[0]),  64'd0);
        check("rst_cnt",   64'(dcnt[0]),   64'd0);
        check("rst_busy",  64'(bsy[0]),    64'd0);
        check("rst_drop",  64'(kdrop[0]),  64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Exact Enter-to-valid latency for a 4-digit code
        type_str(0, "1234");
        @(posedge clk); #1;
        key_ascii = 8'h0D;
        kr[0]     = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (i == 1) kr[0] = 1'b0;
            if (i == 4) check("lat_k4_valid", 64'(cvalid[0]), 64'd0);
            if (i == 5) begin
                check("lat_k5_valid",  64'(cvalid[0]), 64'd1);
                check("lat_k5_data",   64'(cdata[0]),  64'h4D2);
                check("lat_k5_digits", 64'(cdig[0]),   64'd4);
                check("lat_k5_ovf",    64'(covf[0]),   64'd0);
            end
        end
        @(posedge clk); #1;
        check("lat_drop_valid", 64'(cvalid[0]), 64'd0);
        check("lat_cnt0",       64'(dcnt[0]),   64'd0);

        type_str(0, "129");
        press(0, 8'h08);
        type_str(0, "3");
        get_code(0, "bs", 32'd123, 4'd3, 1'b0);

        type_str(0, "4R7");
        get_code(0, "clr", 32'd7, 4'd1, 1'b0);

        press(0, 8'h08);
        check("empty_bs_cnt", 64'(dcnt[0]), 64'd0);
        press(0, 8'h0D);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cvalid[0]) seen = 1'b1;
        end
        check("empty_enter_valid", 64'(seen), 64'd0);
        check("empty_enter_busy",  64'(bsy[0]), 64'd0);

        type_str(1, "dEaD");
        get_code(1, "hex", 32'hDEAD, 4'd4, 1'b0);

        type_str(2, "ZZ");
        get_code(2, "b36", 32'd1295, 4'd2, 1'b0);
        type_str(2, "AB-");
        check("b36_dash_clr", 64'(dcnt[2]), 64'd0);
        type_str(2, "R");
        get_code(2, "b36_R", 32'd27, 4'd1, 1'b0);

        type_str(0, "1234567890123");
        check("trunc_cnt", 64'(dcnt[0]), 64'd12);
        get_code(0, "trunc", 32'hBE991A14, 4'd12, 1'b1);

        type_str(0, "4294967296");
        get_code(0, "wrap", 32'd0, 4'd10, 1'b1);

        // Back-pressure: outputs hold, keys are dropped
        code_ready = 1'b0;
        type_str(0, "42");
        press(0, 8'h0D);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cvalid[0]) seen = 1'b1;
        end
        check("hold_valid_seen", 64'(seen), 64'd1);
        drops  = 0;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            key_ascii = 8'h39;
            kr[0]     = (i == 2 || i == 8 || i == 14);
            @(negedge clk);
            if (kdrop[0]) drops++;
            if (cvalid[0] !== 1'b1 || cdata[0] !== 32'd42 || cdig[0] !== 4'd2 ||
                covf[0] !== 1'b0 || dcnt[0] !== 4'd2) stable = 1'b0;
        end
        check("hold_stable", 64'(stable), 64'd1);
        check("hold_drops",  64'(drops),  64'd3);
        kr[0]      = 1'b0;
        code_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_xfer_valid", 64'(cvalid[0]), 64'd0);
        check("hold_xfer_cnt",   64'(dcnt[0]),   64'd0);
        @(posedge clk); #1;
        check("hold_single", 64'(cvalid[0]), 64'd0);

        // Reset mid-conversion
        type_str(0, "123456");
        press(0, 8'h0D);
        @(posedge clk); #1;
        check("conv_busy", 64'(bsy[0]), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_valid", 64'(cvalid[0]), 64'd0);
        check("midrst_cnt",   64'(dcnt[0]),   64'd0);
        check("midrst_busy",  64'(bsy[0]),    64'd0);
        @(negedge clk);
        reset = 1'b0;

        @(posedge clk); #1;
        key_ascii = 8'h35;
        kr[0]     = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        kr[0] = 1'b0;
        check("held_key_cnt", 64'(dcnt[0]), 64'd1);
        get_code(0, "held_key", 32'd5, 4'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
